// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one imem request at a time,
// holds the fetched word for decode and applies trap/jump redirects. Option: MISALIGN_CHECK_EN.
module pc_fetch_ctrl #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC   = ADDR_W'(32'h100)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              flush_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              drop;
    logic              redirect;
    logic              accept;
    logic              in_flight;
    logic [ADDR_W-1:0] target;

    assign imem_addr_o = pc;

    always_comb begin
        redirect  = trap_i | jump_i;
        accept    = imem_req_o & imem_gnt_i;
        // A response is still owed if we are waiting and it has not arrived, or a grant lands now
        in_flight = ((state == S_WAIT) && !imem_rvalid_i) || ((state == S_REQ) && accept);
    end

`ifdef MISALIGN_CHECK_EN
    logic bad_jump;

    always_comb begin
        bad_jump = jump_i & ~trap_i & (jump_addr_i[1:0] != 2'b00);
        if (trap_i) begin
            target = trap_addr_i;
        end else if (bad_jump) begin
            target = TRAP_VEC;
        end else begin
            target = jump_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= bad_jump;
        end
    end
`else
    logic unused_trap_vec;

    assign unused_trap_vec = ^TRAP_VEC;

    always_comb begin
        target = trap_i ? trap_addr_i : jump_addr_i;
        target = target & ~ADDR_W'(3);
    end

    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_ADDR;
            imem_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            flush_o      <= 1'b0;
            // An abandoned request in flight still returns one rvalid that must be swallowed
            drop         <= (state == S_WAIT);
        end else begin
            flush_o <= 1'b0;
            if (redirect) begin
                pc           <= target;
                inst_valid_o <= 1'b0;
                flush_o      <= 1'b1;
                if (in_flight) begin
                    state      <= S_WAIT;
                    imem_req_o <= 1'b0;
                    drop       <= 1'b1;
                end else begin
                    state      <= S_REQ;
                    imem_req_o <= 1'b1;
                    // Waiting with rvalid now: that response is consumed here and discarded
                    if (state == S_WAIT) begin
                        drop <= 1'b0;
                    end
                end
            end else begin
                case (state)
                    S_REQ: begin
                        if (accept) begin
                            state      <= S_WAIT;
                            imem_req_o <= 1'b0;
                        end else begin
                            imem_req_o <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid_i) begin
                            if (drop) begin
                                drop       <= 1'b0;
                                state      <= S_REQ;
                                imem_req_o <= 1'b1;
                            end else begin
                                inst_o       <= imem_rdata_i;
                                inst_pc_o    <= pc;
                                inst_valid_o <= 1'b1;
                                pc           <= pc + ADDR_W'(4);
                                state        <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall_i) begin
                            inst_valid_o <= 1'b0;
                            state        <= S_REQ;
                            imem_req_o   <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= S_REQ;
                        imem_req_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Table-driven bench for pc_fetch_ctrl with a bench-side imem responder; honours MISALIGN_CHECK_EN.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        trap_i;
    logic [31:0] trap_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        flush_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

`ifdef MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_T    = 32'h100;
    localparam logic        MIS_FLAG = 1'b1;
`else
    localparam logic [31:0] MIS_T    = 32'h200;
    localparam logic        MIS_FLAG = 1'b0;
`endif

    pc_fetch_ctrl #(
        .ADDR_W    (32),
        .RESET_ADDR(32'h0),
        .TRAP_VEC  (32'h100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .trap_i       (trap_i),
        .trap_addr_i  (trap_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .flush_o      (flush_o),
        .misalign_o   (misalign_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Instruction memory contents model
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    // Responder state: one outstanding request, rvalid lat cycles after the grant
    logic        pend = 1'b0;
    logic [31:0] pdata;
    int          cnt = 0;
    int          lat = 1;
    logic        manual = 1'b0;

    task automatic resp_update();
        if (!manual) begin
            imem_rvalid_i = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = pdata;
                    pend          = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (imem_req_o === 1'b1 && imem_gnt_i) begin
                pend  = 1'b1;
                pdata = mem(imem_addr_o);
                cnt   = lat - 1;
            end
        end
    endtask

    task automatic cyc();
        resp_update();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] inst, input logic [31:0] ipc,
                             input logic fl, input logic mis);
        chk($sformatf("%s req", tag), 32'(imem_req_o), 32'(req));
        chk($sformatf("%s addr", tag), imem_addr_o, addr);
        chk($sformatf("%s valid", tag), 32'(inst_valid_o), 32'(vld));
        chk($sformatf("%s inst", tag), inst_o, inst);
        chk($sformatf("%s inst_pc", tag), inst_pc_o, ipc);
        chk($sformatf("%s flush", tag), 32'(flush_o), 32'(fl));
        chk($sformatf("%s misalign", tag), 32'(misalign_o), 32'(mis));
    endtask

    task automatic set_in(input logic st, input logic jp, input logic [31:0] ja);
        stall_i     = st;
        jump_i      = jp;
        jump_addr_i = ja;
        trap_i      = 1'b0;
        trap_addr_i = '0;
    endtask

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] jaddr;
        logic        trap;
        logic [31:0] taddr;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] inst;
        logic [31:0] ipc;
        logic        fl;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic st, input logic jp, input logic [31:0] ja,
                                input logic tp, input logic [31:0] ta,
                                input logic rq, input logic [31:0] ad, input logic vl,
                                input logic [31:0] in, input logic [31:0] pc, input logic fl);
        vec_t v;
        v.stall = st; v.jump = jp; v.jaddr = ja; v.trap = tp; v.taddr = ta;
        v.req = rq; v.addr = ad; v.vld = vl; v.inst = in; v.ipc = pc; v.fl = fl;
        return v;
    endfunction

    initial begin
        // Each row: outputs expected at this negedge, then inputs driven for the next posedge
        tbl[0]  = mk(0, 0, 0, 0, 0,      1, 32'h0,   0, 32'h0,          32'h0,   0);
        tbl[1]  = mk(0, 0, 0, 0, 0,      0, 32'h0,   0, 32'h0,          32'h0,   0);
        tbl[2]  = mk(0, 0, 0, 0, 0,      0, 32'h4,   1, mem(32'h0),     32'h0,   0);
        tbl[3]  = mk(0, 0, 0, 0, 0,      1, 32'h4,   0, mem(32'h0),     32'h0,   0);
        tbl[4]  = mk(0, 0, 0, 0, 0,      0, 32'h4,   0, mem(32'h0),     32'h0,   0);
        tbl[5]  = mk(1, 0, 0, 0, 0,      0, 32'h8,   1, mem(32'h4),     32'h4,   0);
        tbl[6]  = mk(1, 0, 0, 0, 0,      0, 32'h8,   1, mem(32'h4),     32'h4,   0);
        tbl[7]  = mk(1, 0, 0, 0, 0,      0, 32'h8,   1, mem(32'h4),     32'h4,   0);
        tbl[8]  = mk(1, 0, 0, 0, 0,      0, 32'h8,   1, mem(32'h4),     32'h4,   0);
        tbl[9]  = mk(1, 0, 0, 0, 0,      0, 32'h8,   1, mem(32'h4),     32'h4,   0);
        tbl[10] = mk(0, 0, 0, 0, 0,      0, 32'h8,   1, mem(32'h4),     32'h4,   0);
        tbl[11] = mk(0, 0, 0, 0, 0,      1, 32'h8,   0, mem(32'h4),     32'h4,   0);
        tbl[12] = mk(0, 0, 0, 0, 0,      0, 32'h8,   0, mem(32'h4),     32'h4,   0);
        tbl[13] = mk(0, 0, 0, 0, 0,      0, 32'hC,   1, mem(32'h8),     32'h8,   0);
        tbl[14] = mk(0, 1, 32'h200, 1, 32'h80,
                                         1, 32'hC,   0, mem(32'h8),     32'h8,   0);
        tbl[15] = mk(0, 0, 0, 0, 0,      0, 32'h80,  0, mem(32'h8),     32'h8,   1);
        tbl[16] = mk(0, 0, 0, 0, 0,      1, 32'h80,  0, mem(32'h8),     32'h8,   0);
        tbl[17] = mk(0, 0, 0, 0, 0,      0, 32'h80,  0, mem(32'h8),     32'h8,   0);
        tbl[18] = mk(1, 1, 32'h200, 0, 0,
                                         0, 32'h84,  1, mem(32'h80),    32'h80,  0);
        tbl[19] = mk(0, 0, 0, 0, 0,      1, 32'h200, 0, mem(32'h80),    32'h80,  1);
        tbl[20] = mk(0, 0, 0, 0, 0,      0, 32'h200, 0, mem(32'h80),    32'h80,  0);
        tbl[21] = mk(0, 0, 0, 0, 0,      0, 32'h204, 1, mem(32'h200),   32'h200, 0);
        tbl[22] = mk(0, 0, 0, 0, 0,      1, 32'h204, 0, mem(32'h200),   32'h200, 0);

        rst = 1'b1;
        imem_gnt_i = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        set_in(0, 0, 0);
        cyc();
        cyc();
        check_out("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 23; i++) begin
            check_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld,
                      tbl[i].inst, tbl[i].ipc, tbl[i].fl, 1'b0);
            stall_i     = tbl[i].stall;
            jump_i      = tbl[i].jump;
            jump_addr_i = tbl[i].jaddr;
            trap_i      = tbl[i].trap;
            trap_addr_i = tbl[i].taddr;
            cyc();
        end

        // Jump while waiting: stale response for 0x208 must never reach inst_o
        check_out("m0", 0, 32'h204, 0, mem(32'h200), 32'h200, 0, 0);
        cyc();
        check_out("m1", 0, 32'h208, 1, mem(32'h204), 32'h204, 0, 0);
        lat = 3;
        cyc();
        check_out("m2", 1, 32'h208, 0, mem(32'h204), 32'h204, 0, 0);
        cyc();
        check_out("m3", 0, 32'h208, 0, mem(32'h204), 32'h204, 0, 0);
        set_in(0, 1, 32'h200);
        cyc();
        check_out("m4", 0, 32'h200, 0, mem(32'h204), 32'h204, 1, 0);
        set_in(0, 0, 0);
        cyc();
        check_out("m5", 0, 32'h200, 0, mem(32'h204), 32'h204, 0, 0);
        cyc();
        check_out("m6", 1, 32'h200, 0, mem(32'h204), 32'h204, 0, 0);
        lat = 1;
        cyc();
        check_out("m7", 0, 32'h200, 0, mem(32'h204), 32'h204, 0, 0);
        cyc();
        check_out("m8", 0, 32'h204, 1, mem(32'h200), 32'h200, 0, 0);

        // PC wrap
        set_in(0, 1, 32'hFFFF_FFFC);
        cyc();
        check_out("w1", 1, 32'hFFFF_FFFC, 0, mem(32'h200), 32'h200, 1, 0);
        set_in(0, 0, 0);
        cyc();
        check_out("w2", 0, 32'hFFFF_FFFC, 0, mem(32'h200), 32'h200, 0, 0);
        cyc();
        check_out("w3", 0, 32'h0, 1, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 0);
        cyc();
        check_out("w4", 1, 32'h0, 0, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 0);

        // Request held without grant, then misaligned jump
        imem_gnt_i = 1'b0;
        cyc();
        check_out("x1", 1, 32'h0, 0, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 0);
        set_in(0, 1, 32'h202);
        cyc();
        check_out("x2", 1, MIS_T, 0, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1, MIS_FLAG);
        set_in(0, 0, 0);
        imem_gnt_i = 1'b1;
        cyc();
        check_out("x3", 0, MIS_T, 0, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 0);
        cyc();
        check_out("x4", 0, MIS_T + 32'h4, 1, mem(MIS_T), MIS_T, 0, 0);
        cyc();
        check_out("r1", 1, MIS_T + 32'h4, 0, mem(MIS_T), MIS_T, 0, 0);

        // Reset while waiting: the late response lands in the next wait and is discarded
        manual = 1'b1;
        pend = 1'b0;
        imem_rvalid_i = 1'b0;
        cyc();
        check_out("r2", 0, MIS_T + 32'h4, 0, mem(MIS_T), MIS_T, 0, 0);
        rst = 1'b1;
        cyc();
        check_out("r3", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        rst = 1'b0;
        cyc();
        check_out("r4", 1, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        cyc();
        check_out("r5", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hBAD0_BAD0;
        cyc();
        check_out("r6", 1, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        imem_rvalid_i = 1'b0;
        cyc();
        check_out("r7", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = mem(32'h0);
        cyc();
        check_out("r8", 0, 32'h4, 1, mem(32'h0), 32'h0, 0, 0);
        imem_rvalid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
